// File: rtl/switch_mcu_regfile_wr_arb_pkg.sv
// Shared constants and write-request record for the switch MCU regfile write arbiter.
package switch_mcu_pkg;
  localparam int SWITCH_MCU_XLEN   = 32;
  localparam int SWITCH_MCU_REG_AW = 5;
  localparam logic [SWITCH_MCU_REG_AW-1:0] SWITCH_MCU_REG_ZERO = 5'd0;

  typedef struct packed {
    logic [SWITCH_MCU_REG_AW-1:0] addr;
    logic [SWITCH_MCU_XLEN-1:0]   data;
  } wr_req_t;

  // True when two or more bits are set (clearing the lowest set bit leaves something).
  function automatic logic at_least_two(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction
endpackage

// File: rtl/switch_mcu_regfile_wr_arb_if.sv
// Request/write-port bundle between the ALU units (master) and the write arbiter (slave).
interface switch_mcu_regfile_wr_arb_if
  import switch_mcu_pkg::*;
  #(parameter int NUM_REQ = 4, parameter int CNT_W = 16);
  logic                                 in_flush;
  logic [NUM_REQ-1:0]                   in_req;
  logic [NUM_REQ*SWITCH_MCU_REG_AW-1:0] in_waddr;
  logic [NUM_REQ*SWITCH_MCU_XLEN-1:0]   in_wdata;
  logic [NUM_REQ-1:0]                   out_gnt;
  logic                                 out_wen;
  logic [SWITCH_MCU_REG_AW-1:0]         out_waddr;
  logic [SWITCH_MCU_XLEN-1:0]           out_wdata;
  logic                                 out_conflict;
  logic [CNT_W-1:0]                     out_stall_cnt;

  modport master (
    output in_flush, in_req, in_waddr, in_wdata,
    input  out_gnt, out_wen, out_waddr, out_wdata, out_conflict, out_stall_cnt
  );
  modport slave (
    input  in_flush, in_req, in_waddr, in_wdata,
    output out_gnt, out_wen, out_waddr, out_wdata, out_conflict, out_stall_cnt
  );
endinterface

// File: rtl/switch_mcu_regfile_wr_arb_rr_arbiter.sv
// One-hot grant generator; round-robin when SWITCH_MCU_WR_ARB_RR_EN is defined,
// otherwise fixed priority with lowest index winning and no pointer state.
module switch_mcu_rr_arbiter
  import switch_mcu_pkg::*;
  #(parameter int NUM_REQ = 4)
  (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
  );
  logic found;

`ifdef SWITCH_MCU_WR_ARB_RR_EN
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] ptr, ptr_nxt;
  int            idx;

  // Walk the units starting at ptr, wrapping modulo NUM_REQ; first live request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++)
        if (en && !found && idx == i && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) ptr_nxt = PW'((i + 1) % NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (en && !found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
  end
`endif
endmodule

// File: rtl/switch_mcu_regfile_wr_arb.sv
// Regfile write-port arbiter: grant mux, registered write stage with x0 filter, contention stats.
// Build option: SWITCH_MCU_WR_ARB_RR_EN selects round-robin instead of fixed priority.
module switch_mcu_regfile_wr_arb
  import switch_mcu_pkg::*;
  #(parameter int NUM_REQ = 4, parameter int CNT_W = 16)
  (
    input logic                      in_clk,
    input logic                      in_rst,
    switch_mcu_regfile_wr_arb_if.slave bus
  );
  logic [NUM_REQ-1:0] gnt;
  logic               live, multi;
  wr_req_t            sel, wr_q;
  logic               wen_q, conflict_q;
  logic [CNT_W-1:0]   stall_q;

  // Reset and flush both suppress the grant, so nothing reaches the write stage.
  assign live = !in_rst && !bus.in_flush;

  switch_mcu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk (in_clk),
    .rst (in_rst),
    .en  (live),
    .req (bus.in_req),
    .gnt (gnt)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel.addr = sel.addr | ({SWITCH_MCU_REG_AW{gnt[i]}} & bus.in_waddr[i*SWITCH_MCU_REG_AW +: SWITCH_MCU_REG_AW]);
      sel.data = sel.data | ({SWITCH_MCU_XLEN{gnt[i]}}   & bus.in_wdata[i*SWITCH_MCU_XLEN +: SWITCH_MCU_XLEN]);
    end
  end

  assign multi = at_least_two(8'(bus.in_req)) && !bus.in_flush;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wen_q      <= 1'b0;
      wr_q       <= '0;
      conflict_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      wen_q      <= (|gnt) && (sel.addr != SWITCH_MCU_REG_ZERO);
      if (|gnt) wr_q <= sel;
      conflict_q <= multi;
      if (multi && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.out_gnt       = gnt;
  assign bus.out_wen       = wen_q;
  assign bus.out_waddr     = wr_q.addr;
  assign bus.out_wdata     = wr_q.data;
  assign bus.out_conflict  = conflict_q;
  assign bus.out_stall_cnt = stall_q;
endmodule

// File: tb/tb_switch_mcu_regfile_wr_arb.sv
// Directed vector bench for switch_mcu_regfile_wr_arb; covers both arbitration builds.
module tb_switch_mcu_regfile_wr_arb;
  import switch_mcu_pkg::*;

`ifdef SWITCH_MCU_WR_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic in_clk = 1'b0;
  logic in_rst;
  always #5 in_clk = ~in_clk;

  switch_mcu_regfile_wr_arb_if #(.NUM_REQ(4), .CNT_W(16)) bus ();
  switch_mcu_regfile_wr_arb_if #(.NUM_REQ(4), .CNT_W(2))  bus2 ();

  assign bus2.in_flush = bus.in_flush;
  assign bus2.in_req   = bus.in_req;
  assign bus2.in_waddr = bus.in_waddr;
  assign bus2.in_wdata = bus.in_wdata;

  switch_mcu_regfile_wr_arb #(.NUM_REQ(4), .CNT_W(16)) dut (
    .in_clk (in_clk), .in_rst (in_rst), .bus (bus));
  switch_mcu_regfile_wr_arb #(.NUM_REQ(4), .CNT_W(2)) dut_sat (
    .in_clk (in_clk), .in_rst (in_rst), .bus (bus2));

  typedef struct {
    logic        rst;
    logic        flush;
    logic [3:0]  req;
    logic        x0;
    logic [3:0]  gnt;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        conflict;
    logic [15:0] stall;
  } vec_t;

  localparam logic [19:0]  A  = {5'd7, 5'd6, 5'd5, 5'd4};
  localparam logic [19:0]  A0 = {5'd7, 5'd6, 5'd5, 5'd0};
  localparam logic [127:0] D  = {32'h33330003, 32'h22220002, 32'hDEADBEEF, 32'h11110000};
  localparam logic [127:0] D0 = {32'h33330003, 32'h22220002, 32'hDEADBEEF, 32'h00001234};

  int errors = 0;
  int checks = 0;
  vec_t tv[14];

  function automatic vec_t mk(logic r, logic f, logic [3:0] q, logic z, logic [3:0] g,
                              logic w, logic [4:0] a, logic [31:0] d, logic c, logic [15:0] s);
    vec_t v;
    v.rst = r; v.flush = f; v.req = q; v.x0 = z; v.gnt = g;
    v.wen = w; v.waddr = a; v.wdata = d; v.conflict = c; v.stall = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    in_rst = 1'b1; bus.in_flush = 1'b0; bus.in_req = '0; bus.in_waddr = A; bus.in_wdata = D;

    //        rst flush req     x0  gnt                    wen addr          data                                 conf stall
    tv[0]  = mk(1, 0, 4'b0000, 0, 4'b0000,               0, 5'd0,         32'h0,                                0, 16'd0);
    tv[1]  = mk(0, 0, 4'b0010, 0, 4'b0010,               1, 5'd5,         32'hDEADBEEF,                         0, 16'd0);
    tv[2]  = mk(1, 0, 4'b0010, 0, 4'b0000,               0, 5'd0,         32'h0,                                0, 16'd0);
    tv[3]  = mk(0, 0, 4'b1111, 0, 4'b0001,               1, 5'd4,         32'h11110000,                         1, 16'd1);
    tv[4]  = mk(0, 0, 4'b1111, 0, RR ? 4'b0010 : 4'b0001, 1, RR ? 5'd5 : 5'd4, RR ? 32'hDEADBEEF : 32'h11110000, 1, 16'd2);
    tv[5]  = mk(0, 0, 4'b1111, 0, RR ? 4'b0100 : 4'b0001, 1, RR ? 5'd6 : 5'd4, RR ? 32'h22220002 : 32'h11110000, 1, 16'd3);
    tv[6]  = mk(0, 0, 4'b1111, 0, RR ? 4'b1000 : 4'b0001, 1, RR ? 5'd7 : 5'd4, RR ? 32'h33330003 : 32'h11110000, 1, 16'd4);
    tv[7]  = mk(0, 0, 4'b0000, 0, 4'b0000,               0, RR ? 5'd7 : 5'd4, RR ? 32'h33330003 : 32'h11110000, 0, 16'd4);
    tv[8]  = mk(0, 0, 4'b0110, 0, 4'b0010,               1, 5'd5,         32'hDEADBEEF,                         1, 16'd5);
    tv[9]  = mk(0, 0, 4'b0110, 0, RR ? 4'b0100 : 4'b0010, 1, RR ? 5'd6 : 5'd5, RR ? 32'h22220002 : 32'hDEADBEEF, 1, 16'd6);
    tv[10] = mk(0, 1, 4'b0011, 0, 4'b0000,               0, RR ? 5'd6 : 5'd5, RR ? 32'h22220002 : 32'hDEADBEEF, 0, 16'd6);
    tv[11] = mk(0, 0, 4'b0011, 0, 4'b0001,               1, 5'd4,         32'h11110000,                         1, 16'd7);
    tv[12] = mk(0, 0, 4'b0001, 1, 4'b0001,               0, 5'd0,         32'h00001234,                         0, 16'd7);
    tv[13] = mk(0, 0, 4'b1000, 0, 4'b1000,               1, 5'd7,         32'h33330003,                         0, 16'd7);

    for (int i = 0; i < 14; i++) begin
      @(negedge in_clk);
      in_rst       = tv[i].rst;
      bus.in_flush = tv[i].flush;
      bus.in_req   = tv[i].req;
      bus.in_waddr = tv[i].x0 ? A0 : A;
      bus.in_wdata = tv[i].x0 ? D0 : D;
      #1;
      chk($sformatf("v%0d gnt", i), 32'(bus.out_gnt), 32'(tv[i].gnt));
      @(posedge in_clk);
      #1;
      chk($sformatf("v%0d wen", i),      32'(bus.out_wen),       32'(tv[i].wen));
      chk($sformatf("v%0d waddr", i),    32'(bus.out_waddr),     32'(tv[i].waddr));
      chk($sformatf("v%0d wdata", i),    bus.out_wdata,          tv[i].wdata);
      chk($sformatf("v%0d conflict", i), 32'(bus.out_conflict),  32'(tv[i].conflict));
      chk($sformatf("v%0d stall", i),    32'(bus.out_stall_cnt), 32'(tv[i].stall));
    end

    // Saturation: the 2-bit counter sticks at 3 while the 16-bit one keeps counting.
    @(negedge in_clk);
    in_rst = 1'b1; bus.in_flush = 1'b0; bus.in_req = 4'b0000; bus.in_waddr = A; bus.in_wdata = D;
    @(posedge in_clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge in_clk);
      in_rst = 1'b0; bus.in_req = 4'b1111;
      @(posedge in_clk);
      #1;
      chk($sformatf("sat k%0d stall16", k), 32'(bus.out_stall_cnt), 32'(k));
      chk($sformatf("sat k%0d stall2", k),  32'(bus2.out_stall_cnt), (k > 3) ? 32'd3 : 32'(k));
    end

    // Reset with a write pending in the output stage drops it.
    @(negedge in_clk);
    in_rst = 1'b1; bus.in_req = 4'b0000;
    @(posedge in_clk);
    #1;
    chk("rst wen",   32'(bus.out_wen),        32'd0);
    chk("rst waddr", 32'(bus.out_waddr),      32'd0);
    chk("rst stall", 32'(bus2.out_stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
